irq_controller: RTL
===================

// Module: irq_controller
// PURPOSE
//  Memory-mapped machine external interrupt controller; drives the CSR unit's interupt input (mip[11]).
//  Captures N_SRC on-chip requests (accelerator done, UART, ...). Resolves priority: lowest id wins.
//  Provides a claim/complete handshake over the load/store bus so the handler services one source at a time.
// PARAMETERS
//  N_SRC   8  external sources, ids 1..N_SRC (legal range 1..30); id 0 = "none"
//  ADDR_W  8  byte address width of register window
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high reset
//  src_i        in   N_SRC   request lines, synchronous to clk; bit k-1 = id k
//  bus_sel_i    in   1       window selected by LSU address decode
//  bus_wr_i     in   1       store strobe (whole word)
//  bus_rd_i     in   1       load strobe
//  bus_addr_i   in   ADDR_W  byte offset; [1:0] ignored
//  bus_wdata_i  in   32      store data
//  bus_rdata_o  out  32      load data, combinational from current state; 0 when unselected or unmapped
//  irq_o        out  1       registered level to CSR unit interupt
// BEHAVIOUR
//  Map: 0x00 PENDING (RO), 0x04 ENABLE (RW), 0x08 TRIGGER (RW, 1=edge, 0=level), 0x0C CLAIM (R) / COMPLETE (W).
//  Map bit k = id k; bit 0 always reads 0 and ignores writes.
//  Reset: pending, enable, trigger, in_service, src_q, irq_o = 0.
//  Gateway, per id k, evaluated each cycle:
//   - Edge mode: pending[k] set when src_q[k]=0 and src_i[k]=1 (src_q = src_i delayed 1 cycle), regardless of in_service.
//   - Level mode: pending[k] set when src_i[k]=1 and in_service[k]=0.
//  Claim, at the clock edge with sel&rd&addr==0x0C:
//   - bus_rdata_o = lowest id with pending&enable&~in_service, or 0.
//   - If id!=0: pending[id] cleared, in_service[id] set.
//   - If id==0: no state change.
//  Same cycle set and claim-clear on the same id: set wins (edge is not lost).
//  Complete, sel&wr&addr==0x0C: in_service[wdata[4:0]] cleared.
//   - Ignored if id==0, id>max id, or that id is not in service.
//  irq_o <= |(pending & enable & ~in_service). Latency is 1 cycle from the pending/enable/in_service change.
//  Writing ENABLE=0 masks the source but keeps pending. Writing TRIGGER does not clear pending.
//  Reads and writes to other offsets: rdata 0, no effect. Simultaneous rd and wr: write only; no claim.
//  Reset mid-handshake clears in_service. A level source still high re-pends 1 cycle after reset deasserts.
// CONFIGURATION
//  IRQ_CTRL_TIMER_EN defined:
//   - Adds 64-bit mtime, +1 per cycle, wraps to 0.
//   - Adds 64-bit mtimecmp, reset all-ones.
//   - Map: 0x10/0x14 mtime lo/hi (RW), 0x18/0x1C mtimecmp lo/hi (RW).
//   - Timer is level source id N_SRC+1; condition mtime >= mtimecmp (unsigned); same gateway, priority last.
//   - A mtime write overrides the increment that cycle.
//  IRQ_CTRL_TIMER_EN undefined: 0x10-0x1C read 0, writes ignored; id N_SRC+1 never pending.
// STRUCTURE
//  Package irq_ctrl_pkg:
//   - offset localparams OFF_PENDING, OFF_ENABLE, OFF_TRIGGER, OFF_CLAIM, OFF_MTIME_LO/HI, OFF_MTIMECMP_LO/HI
//   - MAX_SRC=31; typedef irq_id_t = logic [4:0]
//  Sub-module irq_gateway: one per id (generate). Holds src_q and pending. Inputs trigger, claim_clr, in_service.
//  Top holds enable, trigger, in_service, the priority encoder, bus decode and the timer.
// TESTING
//  1 Level: enable=0x2, src_i[0]=1 -> irq_o=1 two cycles later; CLAIM reads 1; irq_o=0 next cycle;
//    COMPLETE 1 with src still high -> re-pend, irq_o=1 again.
//  2 Priority: ids 3 and 5 pending, enable=0x28 -> CLAIM 3, then CLAIM 5, then CLAIM 0; irq_o low after second claim.
//  3 Edge: trigger=0x4, 1-cycle pulse on id 2 while id 2 in service -> pending[2]=1;
//    after COMPLETE 2, CLAIM returns 2; edge in the claim cycle is retained.
//  4 Illegal complete: COMPLETE 0, 31, or id not in service -> in_service unchanged; enable=0 masks irq_o but PENDING still reads bit.
//  5 Reset mid-service: claim id 4, assert reset 1 cycle -> all regs 0, irq_o=0; src level high -> irq_o=1 2 cycles after reset (enable rewritten).
//  6 Timer (IRQ_CTRL_TIMER_EN):
//    - mtimecmp=mtime+10 -> irq_o rises 11-12 cycles later; CLAIM returns N_SRC+1.
//    - Writing mtimecmp hi=0xFFFFFFFF de-asserts the source.
//    - Without the macro, offset 0x10 reads 0.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register offsets, id type and mask/priority helpers for irq_controller.
package irq_ctrl_pkg;
   localparam int OFF_PENDING     = 'h00;
   localparam int OFF_ENABLE      = 'h04;
   localparam int OFF_TRIGGER     = 'h08;
   localparam int OFF_CLAIM       = 'h0C;
   localparam int OFF_MTIME_LO    = 'h10;
   localparam int OFF_MTIME_HI    = 'h14;
   localparam int OFF_MTIMECMP_LO = 'h18;
   localparam int OFF_MTIMECMP_HI = 'h1C;
   localparam int MAX_SRC = 31;
   typedef logic [4:0] irq_id_t;
   function automatic logic [31:0] id_range(input int hi);
      logic [31:0] m;
      m = '0;
      for (int k = 1; k <= hi; k++) m[k] = 1'b1;
      return m;
   endfunction
   function automatic irq_id_t lowest_id(input logic [31:0] v);
      irq_id_t id;
      id = '0;
      for (int k = MAX_SRC; k >= 1; k--) if (v[k]) id = irq_id_t'(k);
      return id;
   endfunction
endpackage

// File: rtl/irq_gateway.sv
// irq_gateway: per-id request capture (edge or level) holding the pending bit.
module irq_gateway
   import irq_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_src,
   input  logic i_trigger,
   input  logic i_claim_clr,
   input  logic i_in_service,
   output logic o_pending
);
   logic r_src_q, r_pending, w_set;
   assign w_set = i_trigger ? i_src & ~r_src_q : i_src & ~i_in_service;
   // a new request in the claim cycle outranks the claim clear
   always_ff @(posedge clk)
      if (reset) begin
         r_src_q   <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_src_q   <= i_src;
         r_pending <= w_set | (r_pending & ~i_claim_clr);
      end
   assign o_pending = r_pending;
endmodule

// File: rtl/irq_controller.sv
// irq_controller: memory-mapped external interrupt controller with claim/complete handshake.
// Optional machine timer as source N_SRC+1 when IRQ_CTRL_TIMER_EN is defined.
module irq_controller
   import irq_ctrl_pkg::*;
#(
   parameter int N_SRC  = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_SRC-1:0]  src_i,
   input  logic              bus_sel_i,
   input  logic              bus_wr_i,
   input  logic              bus_rd_i,
   input  logic [ADDR_W-1:0] bus_addr_i,
   input  logic [31:0]       bus_wdata_i,
   output logic [31:0]       bus_rdata_o,
   output logic              irq_o
);
`ifdef IRQ_CTRL_TIMER_EN
   localparam int MAX_ID = N_SRC + 1;
`else
   localparam int MAX_ID = N_SRC;
`endif
   localparam logic [31:0] ID_MASK  = id_range(MAX_ID);
   localparam logic [31:0] SRC_MASK = id_range(N_SRC);
   logic [31:0] r_enable, r_trigger, r_in_service, w_pending, w_cand, w_cmp_clr, w_timer_rdata;
   logic [MAX_ID:1] w_src;
   logic [ADDR_W-1:0] w_off;
   logic w_wr, w_rd, w_claim, r_irq;
   irq_id_t w_claim_id;
   assign w_off      = bus_addr_i & ~ADDR_W'(3);
   assign w_wr       = bus_sel_i & bus_wr_i;
   assign w_rd       = bus_sel_i & bus_rd_i & ~bus_wr_i;
   assign w_cand     = w_pending & r_enable & ~r_in_service;
   assign w_claim_id = lowest_id(w_cand);
   assign w_claim    = w_rd && w_off == ADDR_W'(OFF_CLAIM) && w_claim_id != '0;
   assign w_cmp_clr  = (w_wr && w_off == ADDR_W'(OFF_CLAIM)) ? (32'd1 << bus_wdata_i[4:0]) & ID_MASK : '0;
   for (genvar g = 0; g < 32; g++) begin : g_gw
      if (g >= 1 && g <= MAX_ID) begin : g_on
         irq_gateway u_gw (
            .clk          (clk),
            .reset        (reset),
            .i_src        (w_src[g]),
            .i_trigger    (r_trigger[g]),
            .i_claim_clr  (w_claim && w_claim_id == irq_id_t'(g)),
            .i_in_service (r_in_service[g]),
            .o_pending    (w_pending[g])
         );
      end else begin : g_off
         assign w_pending[g] = 1'b0;
      end
   end
   always_ff @(posedge clk)
      if (reset) begin
         r_enable     <= '0;
         r_trigger    <= '0;
         r_in_service <= '0;
         r_irq        <= 1'b0;
      end else begin
         if (w_wr && w_off == ADDR_W'(OFF_ENABLE)) r_enable <= bus_wdata_i & ID_MASK;
         if (w_wr && w_off == ADDR_W'(OFF_TRIGGER)) r_trigger <= bus_wdata_i & SRC_MASK;
         r_in_service <= (r_in_service | (w_claim ? 32'd1 << w_claim_id : '0)) & ~w_cmp_clr;
         r_irq        <= |w_cand;
      end
   assign irq_o = r_irq;
   assign bus_rdata_o = !bus_sel_i                        ? '0 :
                        w_off == ADDR_W'(OFF_PENDING) ? w_pending :
                        w_off == ADDR_W'(OFF_ENABLE)  ? r_enable :
                        w_off == ADDR_W'(OFF_TRIGGER) ? r_trigger :
                        w_off == ADDR_W'(OFF_CLAIM)   ? 32'(w_claim_id) : w_timer_rdata;
`ifdef IRQ_CTRL_TIMER_EN
   logic [63:0] r_mtime, r_mtimecmp;
   assign w_src = {r_mtime >= r_mtimecmp, src_i};
   assign w_timer_rdata = w_off == ADDR_W'(OFF_MTIME_LO)    ? r_mtime[31:0] :
                          w_off == ADDR_W'(OFF_MTIME_HI)    ? r_mtime[63:32] :
                          w_off == ADDR_W'(OFF_MTIMECMP_LO) ? r_mtimecmp[31:0] :
                          w_off == ADDR_W'(OFF_MTIMECMP_HI) ? r_mtimecmp[63:32] : '0;
   // a software write to mtime replaces that cycle's increment
   always_ff @(posedge clk)
      if (reset) begin
         r_mtime    <= '0;
         r_mtimecmp <= '1;
      end else begin
         r_mtime <= (w_wr && w_off == ADDR_W'(OFF_MTIME_LO)) ? {r_mtime[63:32], bus_wdata_i} :
                    (w_wr && w_off == ADDR_W'(OFF_MTIME_HI)) ? {bus_wdata_i, r_mtime[31:0]} : r_mtime + 64'd1;
         if (w_wr && w_off == ADDR_W'(OFF_MTIMECMP_LO)) r_mtimecmp[31:0] <= bus_wdata_i;
         if (w_wr && w_off == ADDR_W'(OFF_MTIMECMP_HI)) r_mtimecmp[63:32] <= bus_wdata_i;
      end
`else
   assign w_src = src_i;
   assign w_timer_rdata = '0;
`endif
endmodule
